mult_div_unit: RTL and testbench

Iterative signed multiply/divide unit that owns the architectural HI and LO registers of the multicycle MIPS datapath. It executes `mult` (radix-2 Booth, one bit per cycle) and `div` (restoring, one bit per cycle) under control-unit handshakes. It also services `mthi` and `mtlo`. Its `hi`/`lo` outputs feed the write-back data selector directly as its High and Low inputs.

---
 rtl/mult_div_unit_if.sv | 26 ++
 rtl/mult_div_unit.sv | 135 +++++++++++++
 tb/tb_mult_div_unit.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Bus between the control unit and the multiply/divide unit: start handshakes,
// operands, mthi/mtlo writes, and the HI/LO/status returned.
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic             start_mult;
  logic             start_div;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_wr;
  logic             lo_wr;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start_mult, start_div, a, b, hi_wr, lo_wr, wr_data,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start_mult, start_div, a, b, hi_wr, lo_wr, wr_data,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit owning
// the architectural HI/LO registers; one iteration per clock, WIDTH iterations.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             is_div, neg_q, neg_r, dz;
  logic [WIDTH:0]   acc, acc_nxt;
  logic [WIDTH-1:0] qr, qr_nxt, m;
  logic             q_1, q1_nxt;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic [WIDTH:0]   m_ext, booth_sum, shl, trial;
  logic [WIDTH-1:0] abs_a, abs_b, quot, rem;
  logic             accept_mul, accept_div, b_zero, last;

  assign accept_mul = (state == IDLE) && bus.start_mult;
  assign accept_div = (state == IDLE) && !bus.start_mult && bus.start_div;
  assign b_zero     = (bus.b == '0);
  assign last       = (cnt == CW'(WIDTH-1));
  assign abs_a      = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign abs_b      = bus.b[WIDTH-1] ? -bus.b : bus.b;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept_mul || (accept_div && !b_zero)) state_nxt = RUN;
        else if (accept_div)                       state_nxt = FIN;
      end
      RUN:     if (last) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One iteration. Booth keeps a sign guard bit in acc so that adding or
  // subtracting the most negative multiplicand cannot overflow.
  always_comb begin
    m_ext = {m[WIDTH-1], m};
    case ({qr[0], q_1})
      2'b01:   booth_sum = acc + m_ext;
      2'b10:   booth_sum = acc - m_ext;
      default: booth_sum = acc;
    endcase
    shl   = {acc[WIDTH-1:0], qr[WIDTH-1]};
    trial = shl - {1'b0, m};
    if (is_div) begin
      q1_nxt = q_1;
      if (trial[WIDTH]) begin
        acc_nxt = shl;
        qr_nxt  = {qr[WIDTH-2:0], 1'b0};
      end else begin
        acc_nxt = trial;
        qr_nxt  = {qr[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_nxt = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
      qr_nxt  = {booth_sum[0], qr[WIDTH-1:1]};
      q1_nxt  = qr[0];
    end
    quot = neg_q ? -qr_nxt : qr_nxt;
    rem  = neg_r ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      acc    <= '0;
      qr     <= '0;
      m      <= '0;
      q_1    <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      dz <= accept_div && b_zero;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (bus.hi_wr) hi_r <= bus.wr_data;
          if (bus.lo_wr) lo_r <= bus.wr_data;
          if (accept_mul) begin
            acc    <= '0;
            qr     <= bus.a;
            m      <= bus.b;
            q_1    <= 1'b0;
            is_div <= 1'b0;
          end else if (accept_div && !b_zero) begin
            acc    <= '0;
            qr     <= abs_a;
            m      <= abs_b;
            q_1    <= 1'b0;
            is_div <= 1'b1;
            neg_q  <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            neg_r  <= bus.a[WIDTH-1];
          end
        end
        RUN: begin
          acc <= acc_nxt;
          qr  <= qr_nxt;
          q_1 <= q1_nxt;
          cnt <= cnt + CW'(1);
          if (last) begin
            hi_r <= is_div ? rem  : acc_nxt[WIDTH-1:0];
            lo_r <= is_div ? quot : qr_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state == RUN);
  assign bus.done     = (state == FIN);
  assign bus.div_zero = (state == FIN) && dz;
  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed + small random bench for mult_div_unit; expected results are queued
// at issue and compared when done pulses.
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;
  exp_t sb[$];

  mult_div_unit_if #(.WIDTH(32)) bus();
  mult_div_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic is_mul, input logic [31:0] av, input logic [31:0] bv);
    exp_t   e;
    longint p;
    int     sa, sbv;
    e.dz = 1'b0;
    if (is_mul) begin
      p    = longint'($signed(av)) * longint'($signed(bv));
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else begin
      sa   = $signed(av);
      sbv  = $signed(bv);
      e.lo = sa / sbv;
      e.hi = sa % sbv;
    end
    return e;
  endfunction

  // Issue one op, then follow it to done; inj>0 pulses ignored requests in
  // that RUN cycle.
  task automatic run_op(input string tag, input logic sm, input logic sd,
                        input logic [31:0] av, input logic [31:0] bv,
                        input exp_t e, input int inj);
    exp_t        got_e;
    int          busy_n = 0, done_c = 0;
    logic        hold_ok = 1'b1;
    logic [31:0] h0 = '0, l0 = '0;
    sb.push_back(e);
    bus.start_mult = sm; bus.start_div = sd; bus.a = av; bus.b = bv;
    tick();
    bus.start_mult = 1'b0; bus.start_div = 1'b0;
    for (int c = 1; c <= 60 && done_c == 0; c++) begin
      if (c == 1) begin h0 = bus.hi; l0 = bus.lo; end
      if (bus.done) begin
        done_c = c;
        chk({tag, " sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          got_e = sb.pop_front();
          chk({tag, " hi"}, bus.hi, got_e.hi);
          chk({tag, " lo"}, bus.lo, got_e.lo);
          chk({tag, " div_zero"}, bus.div_zero, got_e.dz);
        end
      end else if (bus.busy) begin
        busy_n++;
        if (bus.hi !== h0 || bus.lo !== l0) hold_ok = 1'b0;
      end
      if (c == inj) begin
        bus.start_mult = 1'b1; bus.start_div = 1'b1; bus.hi_wr = 1'b1;
        bus.lo_wr = 1'b1; bus.wr_data = 32'hDEADBEEF; bus.a = 32'h3; bus.b = 32'h0;
      end
      tick();
      if (c == inj) begin
        bus.start_mult = 1'b0; bus.start_div = 1'b0; bus.hi_wr = 1'b0; bus.lo_wr = 1'b0;
      end
    end
    chk({tag, " done_cycle"}, 64'(done_c), e.dz ? 64'd1 : 64'd33);
    chk({tag, " busy_cycles"}, 64'(busy_n), e.dz ? 64'd0 : 64'd32);
    chk({tag, " done_single"}, 64'(bus.done), 64'd0);
    if (!e.dz) chk({tag, " hilo_held_in_run"}, 64'(hold_ok), 64'd1);
  endtask

  function automatic exp_t mk(input logic [31:0] h, input logic [31:0] l, input logic dz);
    exp_t e;
    e.hi = h; e.lo = l; e.dz = dz;
    return e;
  endfunction

  initial begin
    logic        saw;
    logic [31:0] ra, rb;
    bus.start_mult = 1'b0; bus.start_div = 1'b0; bus.a = '0; bus.b = '0;
    bus.hi_wr = 1'b0; bus.lo_wr = 1'b0; bus.wr_data = '0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst hi", bus.hi, 32'h0);
    chk("rst lo", bus.lo, 32'h0);
    chk("rst busy", bus.busy, 1'b0);
    chk("rst done", bus.done, 1'b0);
    chk("rst div_zero", bus.div_zero, 1'b0);

    run_op("mul 7*-3", 1, 0, 32'h7, 32'hFFFFFFFD, mk(32'hFFFFFFFF, 32'hFFFFFFEB, 0), 0);
    run_op("mul min*min", 1, 0, 32'h80000000, 32'h80000000, mk(32'h40000000, 32'h0, 0), 0);
    run_op("mul max*max", 1, 0, 32'h7FFFFFFF, 32'h7FFFFFFF, mk(32'h3FFFFFFF, 32'h1, 0), 0);
    run_op("div -7/2", 0, 1, 32'hFFFFFFF9, 32'h2, mk(32'hFFFFFFFF, 32'hFFFFFFFD, 0), 0);
    run_op("div 7/-2", 0, 1, 32'h7, 32'hFFFFFFFE, mk(32'h1, 32'hFFFFFFFD, 0), 0);
    run_op("div min/-1", 0, 1, 32'h80000000, 32'hFFFFFFFF, mk(32'h0, 32'h80000000, 0), 0);

    bus.hi_wr = 1'b1; bus.wr_data = 32'h11111111;
    tick();
    bus.hi_wr = 1'b0;
    chk("mthi", bus.hi, 32'h11111111);
    bus.lo_wr = 1'b1; bus.wr_data = 32'h22222222;
    tick();
    bus.lo_wr = 1'b0;
    chk("mtlo", bus.lo, 32'h22222222);
    chk("mtlo hi kept", bus.hi, 32'h11111111);
    run_op("div by zero", 0, 1, 32'h5, 32'h0, mk(32'h11111111, 32'h22222222, 1), 0);

    run_op("mul ignore in run", 1, 0, 32'h12345, 32'hFFFF0000,
           model(1, 32'h12345, 32'hFFFF0000), 5);
    run_op("mul+div together", 1, 1, 32'h5, 32'h6, mk(32'h0, 32'd30, 0), 0);

    for (int i = 0; i < 3; i++) begin
      ra = $urandom; rb = $urandom;
      run_op("rand mul", 1, 0, ra, rb, model(1, ra, rb), 0);
      ra = $urandom; rb = $urandom;
      if (rb == 32'h0) rb = 32'h1;
      if (ra == 32'h80000000 && rb == 32'hFFFFFFFF) ra = 32'h1;
      run_op("rand div", 0, 1, ra, rb, model(0, ra, rb), 0);
    end

    run_op("mul pre-reset", 1, 0, 32'h5, 32'h6, mk(32'h0, 32'd30, 0), 0);
    bus.start_mult = 1'b1; bus.a = 32'h3; bus.b = 32'h5;
    tick();
    bus.start_mult = 1'b0;
    repeat (9) tick();
    chk("abort busy before", bus.busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort hi", bus.hi, 32'h0);
    chk("abort lo", bus.lo, 32'h0);
    chk("abort busy", bus.busy, 1'b0);
    chk("abort done", bus.done, 1'b0);
    saw = 1'b0;
    repeat (40) begin
      if (bus.done) saw = 1'b1;
      tick();
    end
    chk("abort no done", saw, 1'b0);

    run_op("mul after reset", 1, 0, 32'hFFFFFFF9, 32'h9, mk(32'hFFFFFFFF, 32'hFFFFFFC1, 0), 0);
    chk("sb drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
